// File: rtl/control_decoder_pipe.sv
// control_decoder_pipe
//   Registered ID-stage control decoder for the rv32im_zbb core. It decodes
//   RV32I, M and optionally Zbb words into the ID/EX control set. The result
//   is held in a one-entry register with a valid/ready handshake, a flush,
//   and an issue lock that covers the multi-cycle M unit.
//
//   Build option: define ZBB_DECODE_EN to decode Zbb. When it is not defined,
//   Zbb encodings decode as illegal and zbb_op_o is always 0.
//
// Parameters
//   MUL_LATENCY  cycles the EX multiplier is occupied per MUL* op (>=1)
//   DIV_LATENCY  cycles the EX divider is occupied per DIV/REM op (>=1)
//
// Ports
//   clk, reset        clock and synchronous active-high reset
//   instr_i           instruction word from IF/ID
//   in_valid_i        instr_i is valid
//   in_ready_o        decoder accepts instr_i this cycle
//   flush_i           kill the held entry and abort any M-unit lock
//   ex_ready_i        EX consumes the held entry this cycle
//   out_valid_o       the control outputs are valid
//   mem_to_reg_o .. rs2_in_use_o, data_mem_we_o, alu_2bit_op_o
//                     decoded control signals (all zero while !out_valid_o)
//   md_op_o           the entry is an M-extension op
//   zbb_op_o          the entry is a Zbb op
//   illegal_o         the entry is an unsupported encoding
//   busy_o            the M-unit lock is active
module control_decoder_pipe #(
  parameter int MUL_LATENCY = 2,
  parameter int DIV_LATENCY = 34
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        flush_i,
  input  logic        ex_ready_i,
  output logic        out_valid_o,
  output logic        mem_to_reg_o,
  output logic        rd_we_o,
  output logic        alu_src_b_o,
  output logic        branch_o,
  output logic        pc_operand_o,
  output logic        rs1_in_use_o,
  output logic        rs2_in_use_o,
  output logic [1:0]  data_mem_we_o,
  output logic [1:0]  alu_2bit_op_o,
  output logic        md_op_o,
  output logic        zbb_op_o,
  output logic        illegal_o,
  output logic        busy_o
);

`ifdef ZBB_DECODE_EN
  localparam bit ZBB_EN = 1'b1;
`else
  localparam bit ZBB_EN = 1'b0;
`endif

  localparam int MAX_LAT = (DIV_LATENCY > MUL_LATENCY) ? DIV_LATENCY : MUL_LATENCY;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] MUL_LM1 = CW'(MUL_LATENCY - 1);
  localparam logic [CW-1:0] DIV_LM1 = CW'(DIV_LATENCY - 1);
  localparam bit MUL_LOCKS = (MUL_LATENCY > 1);
  localparam bit DIV_LOCKS = (DIV_LATENCY > 1);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  typedef struct packed {
    logic       mem_to_reg;
    logic       rd_we;
    logic       alu_src_b;
    logic       branch;
    logic       pc_operand;
    logic       rs1_in_use;
    logic       rs2_in_use;
    logic [1:0] data_mem_we;
    logic [1:0] alu_2bit_op;
    logic       md_op;
    logic       zbb_op;
    logic       illegal;
    logic       lock;   // M op whose unit latency exceeds one cycle
    logic       div;    // funct3[2]: selects DIV_LATENCY over MUL_LATENCY
  } ctrl_t;

  typedef enum logic [1:0] {S_IDLE, S_VALID, S_LOCK} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  ctrl_t           ctrl_q, ctrl_d, dec;
  logic            accept;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rs2;
  logic       zbb_r, zbb_i, shift_i_ok, r_base_ok;
  logic       unused_fields;

  assign opc = instr_i[6:0];
  assign f3  = instr_i[14:12];
  assign f7  = instr_i[31:25];
  assign rs2 = instr_i[24:20];
  assign unused_fields = ^{instr_i[19:15], instr_i[11:7]};

  // Zbb encodings; these only matter when RV32I/M has already rejected the word.
  assign zbb_r = ZBB_EN && (
      (f7 == 7'b0100000 && (f3 == 3'b111 || f3 == 3'b110 || f3 == 3'b100)) ||
      (f7 == 7'b0000101 && f3[2]) ||
      (f7 == 7'b0110000 && (f3 == 3'b001 || f3 == 3'b101)) ||
      (f7 == 7'b0000100 && f3 == 3'b100 && rs2 == 5'd0));
  assign zbb_i = ZBB_EN && (
      (f7 == 7'b0110000 && f3 == 3'b001 &&
       (rs2 == 5'd0 || rs2 == 5'd1 || rs2 == 5'd2 || rs2 == 5'd4 || rs2 == 5'd5)) ||
      (f7 == 7'b0110000 && f3 == 3'b101) ||
      (f7 == 7'b0010100 && f3 == 3'b101 && rs2 == 5'd7) ||
      (f7 == 7'b0110100 && f3 == 3'b101 && rs2 == 5'd24));

  // Shift immediates carry funct7 in the upper immediate bits.
  assign shift_i_ok = (f3 == 3'b001) ? (f7 == 7'b0000000) :
                      (f3 == 3'b101) ? (f7 == 7'b0000000 || f7 == 7'b0100000) : 1'b1;
  assign r_base_ok  = (f7 == 7'b0000000) ||
                      (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));

  always_comb begin
    dec = '0;
    unique case (opc)
      OP_LUI:   begin dec.rd_we = 1'b1; dec.alu_src_b = 1'b1; end
      OP_AUIPC: begin dec.rd_we = 1'b1; dec.alu_src_b = 1'b1; dec.pc_operand = 1'b1; end
      OP_JAL: begin
        dec.rd_we = 1'b1; dec.branch = 1'b1; dec.pc_operand = 1'b1; dec.alu_src_b = 1'b1;
      end
      OP_JALR: begin
        dec.rd_we = 1'b1; dec.branch = 1'b1; dec.alu_src_b = 1'b1; dec.rs1_in_use = 1'b1;
      end
      OP_BR: begin
        dec.branch = 1'b1; dec.alu_2bit_op = 2'b01;
        dec.rs1_in_use = 1'b1; dec.rs2_in_use = 1'b1;
      end
      OP_LD: begin
        dec.mem_to_reg = 1'b1; dec.rd_we = 1'b1; dec.alu_src_b = 1'b1; dec.rs1_in_use = 1'b1;
      end
      OP_ST: begin
        dec.alu_src_b = 1'b1; dec.rs1_in_use = 1'b1; dec.rs2_in_use = 1'b1;
        unique case (f3)
          3'b000:  dec.data_mem_we = 2'b01;
          3'b001:  dec.data_mem_we = 2'b10;
          3'b010:  dec.data_mem_we = 2'b11;
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_IMM: begin
        dec.rd_we = 1'b1; dec.alu_src_b = 1'b1; dec.alu_2bit_op = 2'b11; dec.rs1_in_use = 1'b1;
        if (!shift_i_ok) begin
          if (zbb_i) dec.zbb_op = 1'b1;
          else       dec.illegal = 1'b1;
        end
      end
      OP_REG: begin
        dec.rd_we = 1'b1; dec.alu_2bit_op = 2'b10;
        dec.rs1_in_use = 1'b1; dec.rs2_in_use = 1'b1;
        if (f7 == 7'b0000001) begin
          dec.md_op = 1'b1;
          dec.div   = f3[2];
          dec.lock  = f3[2] ? DIV_LOCKS : MUL_LOCKS;
        end else if (!r_base_ok) begin
          if (zbb_r) dec.zbb_op = 1'b1;
          else       dec.illegal = 1'b1;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
    // Illegal entries carry no side effects downstream; only the flag survives.
    if (dec.illegal) begin
      dec = '0;
      dec.illegal = 1'b1;
    end
  end

  assign out_valid_o = (state_q == S_VALID);
  assign busy_o      = (state_q == S_LOCK);
  // A held locking M op cannot share its consume cycle with a new accept:
  // the entry register is needed empty for the whole lock window.
  assign in_ready_o  = !busy_o && (!out_valid_o || (ex_ready_i && !ctrl_q.lock));
  assign accept      = in_valid_i && in_ready_o && !flush_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (accept) state_d = S_VALID;
        S_VALID: begin
          if (ex_ready_i) begin
            if (ctrl_q.lock) begin
              state_d = S_LOCK;
              cnt_d   = ctrl_q.div ? DIV_LM1 : MUL_LM1;
            end else if (accept) begin
              state_d = S_VALID;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_LOCK: begin
          if (cnt_q <= CW'(1)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    // Keep controls zero whenever no valid entry is held.
    if (accept)                  ctrl_d = dec;
    else if (state_d != S_VALID) ctrl_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign mem_to_reg_o  = ctrl_q.mem_to_reg;
  assign rd_we_o       = ctrl_q.rd_we;
  assign alu_src_b_o   = ctrl_q.alu_src_b;
  assign branch_o      = ctrl_q.branch;
  assign pc_operand_o  = ctrl_q.pc_operand;
  assign rs1_in_use_o  = ctrl_q.rs1_in_use;
  assign rs2_in_use_o  = ctrl_q.rs2_in_use;
  assign data_mem_we_o = ctrl_q.data_mem_we;
  assign alu_2bit_op_o = ctrl_q.alu_2bit_op;
  assign md_op_o       = ctrl_q.md_op;
  assign zbb_op_o      = ctrl_q.zbb_op;
  assign illegal_o     = ctrl_q.illegal;

endmodule

// File: tb/tb_control_decoder_pipe.sv
module tb_control_decoder_pipe;
  localparam int MUL = 2;
  localparam int DIV = 34;
`ifdef ZBB_DECODE_EN
  localparam bit ZB = 1'b1;
`else
  localparam bit ZB = 1'b0;
`endif

  logic        clk, reset;
  logic [31:0] instr_i;
  logic        in_valid_i, in_ready_o, flush_i, ex_ready_i, out_valid_o;
  logic        mem_to_reg_o, rd_we_o, alu_src_b_o, branch_o, pc_operand_o;
  logic        rs1_in_use_o, rs2_in_use_o, md_op_o, zbb_op_o, illegal_o, busy_o;
  logic [1:0]  data_mem_we_o, alu_2bit_op_o;
  logic [13:0] ctrl_vec;

  control_decoder_pipe #(.MUL_LATENCY(MUL), .DIV_LATENCY(DIV)) dut (
    .clk(clk), .reset(reset), .instr_i(instr_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .flush_i(flush_i), .ex_ready_i(ex_ready_i),
    .out_valid_o(out_valid_o), .mem_to_reg_o(mem_to_reg_o), .rd_we_o(rd_we_o),
    .alu_src_b_o(alu_src_b_o), .branch_o(branch_o), .pc_operand_o(pc_operand_o),
    .rs1_in_use_o(rs1_in_use_o), .rs2_in_use_o(rs2_in_use_o),
    .data_mem_we_o(data_mem_we_o), .alu_2bit_op_o(alu_2bit_op_o),
    .md_op_o(md_op_o), .zbb_op_o(zbb_op_o), .illegal_o(illegal_o), .busy_o(busy_o)
  );

  assign ctrl_vec = {mem_to_reg_o, rd_we_o, alu_src_b_o, branch_o, pc_operand_o,
                     rs1_in_use_o, rs2_in_use_o, data_mem_we_o, alu_2bit_op_o,
                     md_op_o, zbb_op_o, illegal_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control vectors {mtr,we,asb,br,pco,rs1,rs2,dmwe,aop,md,zbb,ill}
  localparam logic [13:0] V_R     = 14'b0100011_00_10_000;
  localparam logic [13:0] V_MD    = 14'b0100011_00_10_100;
  localparam logic [13:0] V_LD    = 14'b1110010_00_00_000;
  localparam logic [13:0] V_SB    = 14'b0010011_01_00_000;
  localparam logic [13:0] V_SH    = 14'b0010011_10_00_000;
  localparam logic [13:0] V_SW    = 14'b0010011_11_00_000;
  localparam logic [13:0] V_BR    = 14'b0001011_00_01_000;
  localparam logic [13:0] V_LUI   = 14'b0110000_00_00_000;
  localparam logic [13:0] V_AUIPC = 14'b0110100_00_00_000;
  localparam logic [13:0] V_JAL   = 14'b0111100_00_00_000;
  localparam logic [13:0] V_JALR  = 14'b0111010_00_00_000;
  localparam logic [13:0] V_I     = 14'b0110010_00_11_000;
  localparam logic [13:0] V_ILL   = 14'b0000000_00_00_001;
  localparam logic [13:0] V_ZR    = 14'b0100011_00_10_010;
  localparam logic [13:0] V_ZI    = 14'b0110010_00_11_010;

  localparam logic [31:0] I_ADD  = 32'h002081B3, I_LW  = 32'h0000A183;
  localparam logic [31:0] I_SW   = 32'h0020A023, I_BEQ = 32'h00208063;
  localparam logic [31:0] I_DIV  = 32'h0220C1B3, I_MUL = 32'h022081B3;
  localparam logic [31:0] I_ANDN = 32'h4020F1B3, I_CLZ = 32'h60009193;

  localparam int K_ILL = 0, K_LUI = 1, K_AUIPC = 2, K_JAL = 3, K_JALR = 4, K_BR = 5,
                 K_LD = 6, K_SB = 7, K_SH = 8, K_SW = 9, K_I = 10, K_R = 11, K_MD = 12,
                 K_ZR = 13, K_ZI = 14;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: classify the word by mnemonic family, then look up controls.
  function automatic int kind_of(input logic [31:0] w);
    logic [6:0] f7;
    logic [2:0] f3;
    logic [4:0] r2;
    f7 = w[31:25]; f3 = w[14:12]; r2 = w[24:20];
    case (w[6:0])
      7'h37: return K_LUI;
      7'h17: return K_AUIPC;
      7'h6F: return K_JAL;
      7'h67: return K_JALR;
      7'h63: return K_BR;
      7'h03: return K_LD;
      7'h23: return (f3 == 0) ? K_SB : (f3 == 1) ? K_SH : (f3 == 2) ? K_SW : K_ILL;
      7'h13: begin
        if (f3 != 1 && f3 != 5) return K_I;
        if (f3 == 1 && f7 == 0) return K_I;
        if (f3 == 5 && (f7 == 0 || f7 == 7'h20)) return K_I;
        if (ZB && f7 == 7'h30 && f3 == 1 && (r2 inside {5'd0, 5'd1, 5'd2, 5'd4, 5'd5})) return K_ZI;
        if (ZB && f7 == 7'h30 && f3 == 5) return K_ZI;
        if (ZB && f7 == 7'h14 && f3 == 5 && r2 == 7) return K_ZI;
        if (ZB && f7 == 7'h34 && f3 == 5 && r2 == 24) return K_ZI;
        return K_ILL;
      end
      7'h33: begin
        if (f7 == 0) return K_R;
        if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) return K_R;
        if (f7 == 7'h01) return K_MD;
        if (ZB && f7 == 7'h20 && (f3 inside {3'd4, 3'd6, 3'd7})) return K_ZR;
        if (ZB && f7 == 7'h05 && f3 >= 4) return K_ZR;
        if (ZB && f7 == 7'h30 && (f3 == 1 || f3 == 5)) return K_ZR;
        if (ZB && f7 == 7'h04 && f3 == 4 && r2 == 0) return K_ZR;
        return K_ILL;
      end
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [13:0] ref_ctrl(input logic [31:0] w);
    case (kind_of(w))
      K_LUI: return V_LUI;   K_AUIPC: return V_AUIPC; K_JAL: return V_JAL;
      K_JALR: return V_JALR; K_BR: return V_BR;       K_LD: return V_LD;
      K_SB: return V_SB;     K_SH: return V_SH;       K_SW: return V_SW;
      K_I: return V_I;       K_R: return V_R;         K_MD: return V_MD;
      K_ZR: return V_ZR;     K_ZI: return V_ZI;
      default: return V_ILL;
    endcase
  endfunction

  function automatic int unit_lat(input logic [31:0] w);
    return w[14] ? DIV : MUL;
  endfunction

  // Model state: held entry and remaining lock cycles.
  logic        m_held = 1'b0;
  logic [31:0] m_instr = '0;
  int          m_rem = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  // One clock: drive at negedge, compare against the model, advance both.
  task automatic step(input logic [31:0] w, input logic iv, input logic fl, input logic exr);
    logic [16:0] got, exp;
    logic        hl, ir, acc;
    instr_i = w; in_valid_i = iv; flush_i = fl; ex_ready_i = exr;
    #1;
    hl  = m_held && kind_of(m_instr) == K_MD && unit_lat(m_instr) > 1;
    ir  = (m_rem == 0) && (!m_held || (exr && !hl));
    exp = {ir, m_held, m_rem != 0, m_held ? ref_ctrl(m_instr) : 14'd0};
    got = {in_ready_o, out_valid_o, busy_o, ctrl_vec};
    chk("model", {15'd0, got}, {15'd0, exp});
    @(posedge clk);
    cyc++;
    if (fl) begin
      m_held = 1'b0; m_rem = 0;
    end else begin
      acc = iv && ir;
      if (m_rem > 0) m_rem--;
      if (m_held && exr) begin
        if (hl) m_rem = unit_lat(m_instr) - 1;
        m_held = 1'b0;
      end
      if (acc) begin m_held = 1'b1; m_instr = w; end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    step(32'h0, 1'b0, 1'b0, 1'b1);
    n = 0;
    while ((busy_o || out_valid_o) && n < 100) begin
      step(32'h0, 1'b0, 1'b0, 1'b1);
      n++;
    end
    chk("drain_bound", {31'd0, busy_o | out_valid_o}, 32'd0);
  endtask

  typedef struct { logic [31:0] w; logic [13:0] e; } vec_t;
  vec_t tbl [0:21];

  initial begin
    int n, rdy_hi;
    logic [31:0] w;
    logic [6:0]  opcs [0:8];
    logic [6:0]  f7s [0:7];
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    f7s  = '{7'h00, 7'h20, 7'h01, 7'h05, 7'h30, 7'h04, 7'h14, 7'h34};

    tbl[0]  = '{I_ADD, V_R};            tbl[1]  = '{32'h402081B3, V_R};
    tbl[2]  = '{I_LW, V_LD};            tbl[3]  = '{I_SW, V_SW};
    tbl[4]  = '{32'h00208023, V_SB};    tbl[5]  = '{32'h00209023, V_SH};
    tbl[6]  = '{32'h0020B023, V_ILL};   tbl[7]  = '{I_BEQ, V_BR};
    tbl[8]  = '{32'h000011B7, V_LUI};   tbl[9]  = '{32'h00001197, V_AUIPC};
    tbl[10] = '{32'h000000EF, V_JAL};   tbl[11] = '{32'h000100E7, V_JALR};
    tbl[12] = '{32'h00108193, V_I};     tbl[13] = '{32'h4010D193, V_I};
    tbl[14] = '{32'h40109193, V_ILL};   tbl[15] = '{32'h402091B3, V_ILL};
    tbl[16] = '{I_MUL, V_MD};           tbl[17] = '{I_DIV, V_MD};
    tbl[18] = '{32'h0000007F, V_ILL};   tbl[19] = '{32'h00000000, V_ILL};
    tbl[20] = '{I_ANDN, ZB ? V_ZR : V_ILL};
    tbl[21] = '{I_CLZ,  ZB ? V_ZI : V_ILL};

    reset = 1'b1; instr_i = '0; in_valid_i = 1'b0; flush_i = 1'b0; ex_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready_o},  32'd1);
    chk("rst_busy",      {31'd0, busy_o},      32'd0);
    chk("rst_ctrl",      {18'd0, ctrl_vec},    32'd0);

    // Table: one accept, check the registered entry, then drain any lock.
    for (int i = 0; i < 22; i++) begin
      step(tbl[i].w, 1'b1, 1'b0, 1'b1);
      chk($sformatf("tbl%0d_valid", i), {31'd0, out_valid_o}, 32'd1);
      chk($sformatf("tbl%0d_ctrl", i), {18'd0, ctrl_vec}, {18'd0, tbl[i].e});
      drain();
    end

    // Back-to-back stream, one instruction per cycle.
    step(I_ADD, 1'b1, 1'b0, 1'b1); chk("strm_add", {18'd0, ctrl_vec}, {18'd0, V_R});
    step(I_LW,  1'b1, 1'b0, 1'b1); chk("strm_lw",  {18'd0, ctrl_vec}, {18'd0, V_LD});
    step(I_SW,  1'b1, 1'b0, 1'b1); chk("strm_sw",  {30'd0, data_mem_we_o}, 32'd3);
    step(I_BEQ, 1'b1, 1'b0, 1'b1);
    chk("strm_beq", {29'd0, branch_o, alu_2bit_op_o}, 32'b101);
    chk("strm_valid", {31'd0, out_valid_o}, 32'd1);
    drain();

    // DIV lock window.
    step(I_DIV, 1'b1, 1'b0, 1'b1);
    chk("div_md", {31'd0, md_op_o}, 32'd1);
    step(I_ADD, 1'b1, 1'b0, 1'b1);
    n = 0; rdy_hi = 0;
    while (busy_o && n < 100) begin
      if (in_ready_o) rdy_hi++;
      n++;
      step(I_ADD, 1'b1, 1'b0, 1'b1);
    end
    chk("div_busy_cycles", n, 33);
    chk("div_lock_ready", rdy_hi, 0);
    step(I_ADD, 1'b1, 1'b0, 1'b1);
    chk("div_then_add", {13'd0, out_valid_o, busy_o, ctrl_vec, in_ready_o}, {13'd0, 1'b1, 1'b0, V_R, 1'b1});
    drain();

    // MUL lock is a single cycle.
    step(I_MUL, 1'b1, 1'b0, 1'b1);
    step(32'h0, 1'b0, 1'b0, 1'b1);
    chk("mul_busy", {31'd0, busy_o}, 32'd1);
    step(32'h0, 1'b0, 1'b0, 1'b1);
    chk("mul_free", {30'd0, busy_o, in_ready_o}, 32'b01);

    // Entry held while EX stalls.
    step(I_LW, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(I_ADD, 1'b1, 1'b0, 1'b0);
      chk("hold_ctrl", {17'd0, out_valid_o, ctrl_vec}, {17'd0, 1'b1, V_LD});
      chk("hold_ready", {31'd0, in_ready_o}, 32'd0);
    end
    drain();

    // Flush during LOCK, then during VALID with a competing accept.
    step(I_DIV, 1'b1, 1'b0, 1'b1);
    step(I_ADD, 1'b1, 1'b0, 1'b1);
    step(I_ADD, 1'b1, 1'b0, 1'b1);
    step(I_ADD, 1'b1, 1'b1, 1'b1);
    chk("flush_lock", {30'd0, out_valid_o, busy_o}, 32'd0);
    chk("flush_lock_ready", {31'd0, in_ready_o}, 32'd1);
    step(I_LW, 1'b1, 1'b0, 1'b0);
    step(I_SW, 1'b1, 1'b1, 1'b1);
    chk("flush_valid", {17'd0, out_valid_o, ctrl_vec}, 32'd0);
    step(32'h0, 1'b0, 1'b0, 1'b1);
    chk("flush_dropped", {31'd0, out_valid_o}, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: w = tbl[$urandom_range(0, 21)].w;
        1: w = $urandom;
        default: begin
          w = $urandom;
          w[6:0]   = opcs[$urandom_range(0, 8)];
          w[31:25] = f7s[$urandom_range(0, 7)];
          if ($urandom_range(0, 1) == 1) w[24:20] = 5'($urandom_range(0, 7));
        end
      endcase
      step(w, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
